// File: rtl/cdc_handshake_rx_if.sv
// Bus bundle for the receiving side of the four-phase req/ack crossing:
// source-domain req/data/ack plus the local valid/ready stream and status.
`timescale 1ns/1ps

interface cdc_handshake_rx_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   src_req;
    logic [DATA_WIDTH-1:0]  src_data;
    logic                   src_ack;
    logic [DATA_WIDTH-1:0]  dst_data;
    logic                   dst_valid;
    logic                   dst_ready;
    logic                   dst_proto_err;
    logic [COUNT_WIDTH-1:0] dst_count;

    modport master (
        output src_req, src_data, dst_ready,
        input  src_ack, dst_data, dst_valid, dst_proto_err, dst_count
    );

    modport slave (
        input  src_req, src_data, dst_ready,
        output src_ack, dst_data, dst_valid, dst_proto_err, dst_count
    );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-side four-phase handshake receiver: synchronizes src_req, captures
// the source word once, presents it as a valid/ready stream and returns src_ack.
`timescale 1ns/1ps

module cdc_handshake_rx #(
    parameter int pDATA_WIDTH  = 32,
    parameter int pSYNC_STAGES = 2,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                 dst_clk,
    input  logic                 reset_n,
    cdc_handshake_rx_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    (* ASYNC_REG = "TRUE" *) logic [pSYNC_STAGES-1:0] req_sync_r;
    logic                    req_s;

    state_t                  state_r, state_s;
    logic [pDATA_WIDTH-1:0]  data_r,  data_s;
    logic                    valid_r, valid_s;
    logic                    ack_r,   ack_s;
    logic                    err_r,   err_s;
    logic [pCOUNT_WIDTH-1:0] count_r, count_s;

    assign req_s = req_sync_r[pSYNC_STAGES-1];

    // src_req synchronizer chain; src_data is deliberately not synchronized
    always_ff @(posedge dst_clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync_r <= '0;
        end else begin
            req_sync_r <= {req_sync_r[pSYNC_STAGES-2:0], bus.src_req};
        end
    end

    // State and registered outputs
    always_ff @(posedge dst_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            data_r  <= '0;
            valid_r <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            count_r <= count_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        valid_s = valid_r;
        ack_s   = ack_r;
        err_s   = 1'b0;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    data_s  = bus.src_data;
                    valid_s = 1'b1;
                    state_s = ST_VALID;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VALID: begin
                // A consumer accept wins over a simultaneous early req drop
                if (valid_r && bus.dst_ready) begin
                    valid_s = 1'b0;
                    ack_s   = 1'b1;
                    count_s = count_r + pCOUNT_WIDTH'(1);
                    state_s = ST_ACK;
                end else if (!req_s) begin
                    valid_s = 1'b0;
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_VALID;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACK;
                end
            end
            default: begin
                valid_s = 1'b0;
                ack_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.src_ack       = ack_r;
    assign bus.dst_data      = data_r;
    assign bus.dst_valid     = valid_r;
    assign bus.dst_proto_err = err_r;
    assign bus.dst_count     = count_r;

endmodule
